fold_search_queue: RTL and testbench

//  Hardware string queue holding up to DEPTH entries of CHARS ASCII bytes each.

---
 rtl/fold_search_queue.sv | 163 ++++++++++++++++
 tb/tb_fold_search_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fold_search_queue.sv
// String queue of DEPTH entries (CHARS bytes each) with sequential locator commands:
// FIND_LAST, FIND_FIRST and COUNT_UNIQUE, each optionally comparing after ASCII upper-casing.
module fold_search_queue #(
    parameter int CHARS = 4,
    parameter int DEPTH = 8,
    localparam int EW = 8 * CHARS,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [EW-1:0] push_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic          cmd_fold,
    input  logic [EW-1:0] cmd_key,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_found,
    output logic [IW-1:0] rsp_index,
    output logic [EW-1:0] rsp_data,
    output logic [CW-1:0] rsp_count,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    function automatic logic [EW-1:0] fold_up(input logic [EW-1:0] v, input logic en);
        logic [EW-1:0] r;
        r = v;
        for (int b = 0; b < CHARS; b++) begin
            if (en && v[8*b +: 8] >= 8'h61 && v[8*b +: 8] <= 8'h7A)
                r[8*b + 5] = 1'b0;
        end
        return r;
    endfunction

    state_t        r_state, w_state_nxt;
    logic [EW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_count, r_n, r_i, r_j, r_rem, r_uniq;
    logic [EW-1:0] r_key;
    logic          r_fold, r_is_cu, r_last;
    logic          r_rsp_found;
    logic [IW-1:0] r_rsp_index;
    logic [EW-1:0] r_rsp_data;
    logic [CW-1:0] r_rsp_count;

    logic          w_cmd_acc, w_push_acc, w_cmd_ready, w_push_ready;
    logic [EW-1:0] w_lhs, w_rhs;
    logic          w_eq, w_self, w_cu_adv, w_last_i, w_scan_done;

    assign w_cmd_acc  = cmd_valid && w_cmd_ready && !clear;
    assign w_push_acc = push_valid && w_push_ready && !clear;

    // Compare datapath: i is the probed entry, j the earlier entry (COUNT_UNIQUE) or the key
    assign w_lhs       = fold_up(r_mem[r_i[IW-1:0]], r_fold);
    assign w_rhs       = r_is_cu ? fold_up(r_mem[r_j[IW-1:0]], r_fold) : fold_up(r_key, r_fold);
    assign w_eq        = (w_lhs == w_rhs);
    assign w_self      = (r_j == r_i);
    assign w_cu_adv    = w_self || w_eq;
    assign w_last_i    = ((r_i + ONE) == r_n);
    assign w_scan_done = r_is_cu ? (w_cu_adv && w_last_i) : (w_eq || (r_rem == ONE));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_acc) w_state_nxt = (r_count == '0) ? S_RESP : S_SCAN;
            S_SCAN:  if (w_scan_done) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_cmd_ready  = (r_state == S_IDLE) && !rst;
        w_push_ready = (r_state == S_IDLE) && !rst && (r_count != CW'(DEPTH));
        rsp_valid    = (r_state == S_RESP);
    end

    assign cmd_ready  = w_cmd_ready;
    assign push_ready = w_push_ready;

    always_ff @(posedge clk) begin
        if (w_push_acc) r_mem[r_count[IW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear)    r_count <= '0;
        else if (w_push_acc) r_count <= r_count + ONE;
    end

    // The snapshot of count taken here excludes a push accepted in the same cycle
    always_ff @(posedge clk) begin
        if (w_cmd_acc) begin
            r_n     <= r_count;
            r_key   <= cmd_key;
            r_fold  <= cmd_fold;
            r_is_cu <= (cmd_op == 2'd2);
            r_last  <= (cmd_op == 2'd0);
            r_i     <= (cmd_op == 2'd0) ? r_count - ONE : '0;
            r_j     <= '0;
            r_rem   <= r_count;
            r_uniq  <= '0;
        end else if (r_state == S_SCAN) begin
            if (r_is_cu) begin
                if (w_cu_adv) begin
                    r_i <= r_i + ONE;
                    r_j <= '0;
                    if (w_self) r_uniq <= r_uniq + ONE;
                end else begin
                    r_j <= r_j + ONE;
                end
            end else begin
                r_i   <= r_last ? r_i - ONE : r_i + ONE;
                r_rem <= r_rem - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_found <= 1'b0;
            r_rsp_index <= '0;
            r_rsp_data  <= '0;
            r_rsp_count <= '0;
        end else if (!clear) begin
            if (w_cmd_acc && r_count == '0) begin
                r_rsp_found <= 1'b0;
                r_rsp_index <= '0;
                r_rsp_data  <= '0;
                r_rsp_count <= '0;
            end else if (r_state == S_SCAN && w_scan_done) begin
                r_rsp_found <= !r_is_cu && w_eq;
                r_rsp_index <= (!r_is_cu && w_eq) ? r_i[IW-1:0] : '0;
                r_rsp_data  <= (!r_is_cu && w_eq) ? r_mem[r_i[IW-1:0]] : '0;
                r_rsp_count <= r_is_cu ? (r_uniq + (w_self ? ONE : '0)) : '0;
            end
        end
    end

    assign rsp_found = r_rsp_found;
    assign rsp_index = r_rsp_index;
    assign rsp_data  = r_rsp_data;
    assign rsp_count = r_rsp_count;
    assign count     = r_count;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);

endmodule

// File: tb/tb_fold_search_queue.sv
// Scoreboard bench for fold_search_queue (CHARS=1, DEPTH=8): directed commands push
// expected responses; a negedge monitor checks latency and response fields.
module tb_fold_search_queue;
    localparam int CHARS = 1, DEPTH = 8, EW = 8, IW = 3, CW = 4;

    logic          clk = 1'b0;
    logic          rst, clear, push_valid, push_ready, cmd_valid, cmd_ready, cmd_fold;
    logic [EW-1:0] push_data, cmd_key, rsp_data;
    logic [1:0]    cmd_op;
    logic          rsp_valid, rsp_ready, rsp_found, full, empty;
    logic [IW-1:0] rsp_index;
    logic [CW-1:0] rsp_count, count;

    always #5 clk = ~clk;

    fold_search_queue #(.CHARS(CHARS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_fold(cmd_fold), .cmd_key(cmd_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_found(rsp_found),
        .rsp_index(rsp_index), .rsp_data(rsp_data), .rsp_count(rsp_count),
        .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        string      nm;
        logic       is_cu;
        logic       found;
        logic [2:0] idx;
        logic [7:0] data;
        logic [3:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0, failures = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                chk({sb[0].nm, "_latency"}, cyc, sb[0].cyc);
            end
        end
        if (rsp_valid && rsp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.nm, "_found"}, 32'(rsp_found), 32'(e.found));
            chk({e.nm, "_index"}, 32'(rsp_index), 32'(e.idx));
            chk({e.nm, "_data"},  32'(rsp_data),  32'(e.data));
            if (e.is_cu) chk({e.nm, "_count"}, 32'(rsp_count), 32'(e.cnt));
        end
        prev_v = rsp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        push_valid = 1'b1;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [1:0] op, input logic f, input logic [7:0] key,
                         input logic ef, input logic [2:0] ei, input logic [7:0] ed,
                         input logic [3:0] ec, input int lat);
        exp_t e;
        e.nm = nm; e.is_cu = (op == 2'd2); e.found = ef; e.idx = ei; e.data = ed;
        e.cnt = ec; e.cyc = cyc + lat;
        sb.push_back(e);
        cmd_valid = 1'b1; cmd_op = op; cmd_fold = f; cmd_key = key;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got timeout with %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; push_valid = 1'b0; push_data = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_fold = 1'b0; cmd_key = '0; rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_push_ready", 32'(push_ready), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_fields", {rsp_found, rsp_index, rsp_data, rsp_count}, 0);
        chk("reset_cmd_ready", 32'(cmd_ready), 1);

        push("a"); push("A"); push("b");
        chk("count3", 32'(count), 3);
        issue("cu_fold", 2'd2, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 4'd2, 6); wait_idle();
        issue("cu_nofold", 2'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 4'd3, 7); wait_idle();
        issue("fl_a_fold", 2'd0, 1'b1, "a", 1'b1, 3'd1, "A", 4'd0, 3); wait_idle();
        issue("ff_a_fold", 2'd1, 1'b1, "a", 1'b1, 3'd0, "a", 4'd0, 2); wait_idle();
        issue("ff_A_nofold", 2'd1, 1'b0, "A", 1'b1, 3'd1, "A", 4'd0, 3); wait_idle();
        issue("ff_z_fold", 2'd1, 1'b1, "z", 1'b0, 3'd0, 8'h00, 4'd0, 4); wait_idle();
        issue("op3_b", 2'd3, 1'b0, "b", 1'b1, 3'd2, "b", 4'd0, 4); wait_idle();

        push("c"); push("d"); push("e"); push("f"); push("B");
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), 8);
        chk("full_push_ready", 32'(push_ready), 0);
        push("x");
        chk("ninth_push_count", 32'(count), 8);
        issue("cu8_fold", 2'd2, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 4'd6, 31); wait_idle();
        issue("cu8_nofold", 2'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 4'd8, 37); wait_idle();

        rsp_ready = 1'b0;
        issue("hold_fl_B", 2'd0, 1'b0, "B", 1'b1, 3'd7, "B", 4'd0, 2);
        for (int n = 0; n < 10 && !rsp_valid; n++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_fields", {rsp_found, rsp_index, rsp_data}, {1'b1, 3'd7, 8'h42});
            chk("hold_cmd_ready", 32'(cmd_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_idle();

        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_count", 32'(count), 0);
        chk("clear_empty", 32'(empty), 1);
        chk("clear_push_ready", 32'(push_ready), 1);

        push("a"); push("A"); push("b");
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_fold = 1'b0; tick(); cmd_valid = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        chk("rst_scan_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_scan_count", 32'(count), 0);
        chk("rst_scan_empty", 32'(empty), 1);
        chk("rst_scan_rsp_fields", {rsp_found, rsp_index, rsp_data, rsp_count}, 0);

        push_valid = 1'b1; push_data = "q";
        issue("same_cycle_fl_q", 2'd0, 1'b0, "q", 1'b0, 3'd0, 8'h00, 4'd0, 1);
        push_valid = 1'b0;
        chk("same_cycle_count", 32'(count), 1);
        wait_idle();
        issue("repeat_fl_q", 2'd0, 1'b0, "q", 1'b1, 3'd0, "q", 4'd0, 2); wait_idle();

        push(8'h60); push(8'h7B);
        issue("ff_at_fold", 2'd1, 1'b1, 8'h40, 1'b0, 3'd0, 8'h00, 4'd0, 4); wait_idle();
        issue("ff_lbrk_fold", 2'd1, 1'b1, 8'h5B, 1'b0, 3'd0, 8'h00, 4'd0, 4); wait_idle();
        issue("ff_bq_fold", 2'd1, 1'b1, 8'h60, 1'b1, 3'd1, 8'h60, 4'd0, 3); wait_idle();
        issue("ff_Q_fold", 2'd1, 1'b1, "Q", 1'b1, 3'd0, "q", 4'd0, 2); wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
